// File: rtl/clk_gate_sched_ctrl.sv
// rtl/clk_gate_sched_ctrl.sv - ADC scheduler HF clock-enable controller on the 100 kHz oscillator clock
// Gated/running/hold-off FSM with wake capture and saturating gating statistics.
module clk_gate_sched_ctrl #(
  parameter int                NUM_REQ     = 3,
  parameter int                CSEL_W      = 2,
  parameter logic [CSEL_W-1:0] SLEEP_SEL   = CSEL_W'(1),
  parameter int                HOLD_CYCLES = 4,
  parameter int                CNT_W       = 16
) (
  input  logic                 clk_osc_100k,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   ungate_req,
  input  logic [NUM_REQ-1:0]   ungate_mask,
  input  logic                 reset_timer_done,
  input  logic                 adc_run,
  input  logic                 en_sleepmode,
  input  logic [CSEL_W-1:0]    clock_select,
  input  logic                 dis_hfclock_gating,
  input  logic                 cnt_clr,
  output logic                 clk_en,
  output logic [1:0]           gate_state,
  output logic                 wake_pulse,
  output logic [NUM_REQ+3:0]   wake_src,
  output logic [CNT_W-1:0]     gate_events,
  output logic [CNT_W-1:0]     active_cycles
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    GATED   = 2'd0,
    RUNNING = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 clk_en_q, clk_en_d;
  logic                 wake_pulse_q, wake_pulse_d;
  logic [NUM_REQ+3:0]   wake_src_q, wake_src_d;
  logic [CNT_W-1:0]     gate_events_q, gate_events_d;
  logic [CNT_W-1:0]     active_cycles_q, active_cycles_d;

  logic                 sleep_run;
  logic [NUM_REQ-1:0]   req_masked;
  logic                 req_any;
  logic [NUM_REQ+3:0]   src_vec;
  logic                 gate_evt;

  assign sleep_run  = !en_sleepmode && (clock_select != SLEEP_SEL);
  assign req_masked = ungate_req & ungate_mask;
  assign req_any    = (|req_masked) | reset_timer_done | adc_run | sleep_run | dis_hfclock_gating;
  assign src_vec    = {req_masked, reset_timer_done, adc_run, sleep_run, dis_hfclock_gating};

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    wake_pulse_d = 1'b0;
    wake_src_d   = wake_src_q;
    unique case (state_q)
      GATED: begin
        if (req_any) begin
          state_d      = RUNNING;
          wake_pulse_d = 1'b1;
          wake_src_d   = src_vec;
        end
      end
      RUNNING: begin
        if (!req_any) begin
          if (HOLD_CYCLES == 0) begin
            state_d = GATED;
          end else begin
            state_d = HOLDOFF;
            hold_d  = HOLD_INIT;
          end
        end
      end
      HOLDOFF: begin
        // A returning request cancels the hold-off without being treated as a wake.
        if (req_any) begin
          state_d = RUNNING;
          hold_d  = '0;
        end else if (hold_q == '0) begin
          state_d = GATED;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: begin
        state_d = GATED;
        hold_d  = '0;
      end
    endcase
  end

  assign clk_en_d = (state_d != GATED);
  assign gate_evt = (state_q != GATED) && (state_d == GATED);

  always_comb begin
    gate_events_d   = gate_events_q;
    active_cycles_d = active_cycles_q;
    if (cnt_clr) begin
      gate_events_d   = '0;
      active_cycles_d = '0;
    end else begin
      if (gate_evt && (gate_events_q != {CNT_W{1'b1}})) begin
        gate_events_d = gate_events_q + 1'b1;
      end
      if (clk_en_q && (active_cycles_q != {CNT_W{1'b1}})) begin
        active_cycles_d = active_cycles_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_osc_100k) begin
    if (reset) begin
      state_q         <= GATED;
      hold_q          <= '0;
      clk_en_q        <= 1'b0;
      wake_pulse_q    <= 1'b0;
      wake_src_q      <= '0;
      gate_events_q   <= '0;
      active_cycles_q <= '0;
    end else begin
      state_q         <= state_d;
      hold_q          <= hold_d;
      clk_en_q        <= clk_en_d;
      wake_pulse_q    <= wake_pulse_d;
      wake_src_q      <= wake_src_d;
      gate_events_q   <= gate_events_d;
      active_cycles_q <= active_cycles_d;
    end
  end

  assign clk_en        = clk_en_q;
  assign gate_state    = state_q;
  assign wake_pulse    = wake_pulse_q;
  assign wake_src      = wake_src_q;
  assign gate_events   = gate_events_q;
  assign active_cycles = active_cycles_q;

endmodule

// File: tb/tb_clk_gate_sched_ctrl.sv
// tb/tb_clk_gate_sched_ctrl.sv - self-checking bench for clk_gate_sched_ctrl
module tb_clk_gate_sched_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] ungate_req;
  logic [2:0] ungate_mask;
  logic       reset_timer_done;
  logic       adc_run;
  logic       en_sleepmode;
  logic [1:0] clock_select;
  logic       dis_hfclock_gating;
  logic       cnt_clr;

  logic        clk_en, wake_pulse;
  logic [1:0]  gate_state;
  logic [6:0]  wake_src;
  logic [15:0] gate_events, active_cycles;

  logic        s_clk_en, s_wake_pulse;
  logic [1:0]  s_gate_state;
  logic [6:0]  s_wake_src;
  logic [3:0]  s_gate_events, s_active_cycles;

  typedef struct packed {
    logic       en;
    logic [1:0] st;
    logic       wp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  clk_gate_sched_ctrl dut (
    .clk_osc_100k(clk), .reset(reset), .ungate_req(ungate_req), .ungate_mask(ungate_mask),
    .reset_timer_done(reset_timer_done), .adc_run(adc_run), .en_sleepmode(en_sleepmode),
    .clock_select(clock_select), .dis_hfclock_gating(dis_hfclock_gating), .cnt_clr(cnt_clr),
    .clk_en(clk_en), .gate_state(gate_state), .wake_pulse(wake_pulse), .wake_src(wake_src),
    .gate_events(gate_events), .active_cycles(active_cycles)
  );

  clk_gate_sched_ctrl #(.CNT_W(4)) dut_s (
    .clk_osc_100k(clk), .reset(reset), .ungate_req(ungate_req), .ungate_mask(ungate_mask),
    .reset_timer_done(reset_timer_done), .adc_run(adc_run), .en_sleepmode(en_sleepmode),
    .clock_select(clock_select), .dis_hfclock_gating(dis_hfclock_gating), .cnt_clr(cnt_clr),
    .clk_en(s_clk_en), .gate_state(s_gate_state), .wake_pulse(s_wake_pulse), .wake_src(s_wake_src),
    .gate_events(s_gate_events), .active_cycles(s_active_cycles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; ungate_req = '0; ungate_mask = '0; reset_timer_done = 0; adc_run = 0;
    en_sleepmode = 1'b1; clock_select = 2'b00; dis_hfclock_gating = 0; cnt_clr = 0;
    for (int i = 0; i < 5; i++) begin
      reset = (i < 3);
      sb.push_back('{en: 1'b0, st: 2'd0, wp: 1'b0});
      tick();
      e = sb.pop_front();
      n_chk++;
      if (clk_en !== e.en || gate_state !== e.st || wake_pulse !== e.wp) begin
        n_fail++;
        $display("FAIL reset step %0d: got en=%b st=%0d wp=%b, expected en=%b st=%0d wp=%b",
                 i, clk_en, gate_state, wake_pulse, e.en, e.st, e.wp);
      end
      n_chk++;
      if (gate_events !== 16'd0 || active_cycles !== 16'd0 || wake_src !== 7'd0) begin
        n_fail++;
        $display("FAIL reset_counters step %0d: got ge=%0d ac=%0d ws=%b, expected 0 0 0",
                 i, gate_events, active_cycles, wake_src);
      end
    end
  endtask

  task automatic test_wake();
    int         st_e[8] = '{1, 1, 2, 2, 2, 2, 0, 0};
    logic [7:0] en_e = 8'b0011_1111;
    logic [7:0] wp_e = 8'b0000_0001;
    exp_t       e;
    ungate_mask = 3'b111; en_sleepmode = 1'b1; clock_select = 2'b01;
    for (int i = 0; i < 8; i++) begin
      ungate_req = (i < 2) ? 3'b010 : 3'b000;
      sb.push_back('{en: en_e[i], st: 2'(st_e[i]), wp: wp_e[i]});
      tick();
      e = sb.pop_front();
      n_chk++;
      if (clk_en !== e.en || gate_state !== e.st || wake_pulse !== e.wp) begin
        n_fail++;
        $display("FAIL wake step %0d: got en=%b st=%0d wp=%b, expected en=%b st=%0d wp=%b",
                 i, clk_en, gate_state, wake_pulse, e.en, e.st, e.wp);
      end
      if (i == 0) begin
        n_chk++;
        if (wake_src !== 7'b0100000) begin
          n_fail++;
          $display("FAIL wake_src_req1: got %b, expected 0100000", wake_src);
        end
      end
    end
    n_chk++;
    if (gate_events !== 16'd1 || active_cycles !== 16'd6) begin
      n_fail++;
      $display("FAIL wake_counters: got ge=%0d ac=%0d, expected ge=1 ac=6", gate_events, active_cycles);
    end
  endtask

  task automatic test_holdoff_reassert();
    int         st_e[9] = '{1, 2, 2, 1, 2, 2, 2, 2, 0};
    logic [8:0] en_e = 9'b0_1111_1111;
    logic [8:0] wp_e = 9'b0_0000_0001;
    exp_t       e;
    ungate_req = '0;
    for (int i = 0; i < 9; i++) begin
      adc_run = (i == 0) || (i == 3);
      sb.push_back('{en: en_e[i], st: 2'(st_e[i]), wp: wp_e[i]});
      tick();
      e = sb.pop_front();
      n_chk++;
      if (clk_en !== e.en || gate_state !== e.st || wake_pulse !== e.wp) begin
        n_fail++;
        $display("FAIL holdoff step %0d: got en=%b st=%0d wp=%b, expected en=%b st=%0d wp=%b",
                 i, clk_en, gate_state, wake_pulse, e.en, e.st, e.wp);
      end
      if (i == 0) begin
        n_chk++;
        if (wake_src !== 7'b0000100) begin
          n_fail++;
          $display("FAIL wake_src_adc_run: got %b, expected 0000100", wake_src);
        end
      end
      if (i == 3) begin
        n_chk++;
        if (gate_events !== 16'd1) begin
          n_fail++;
          $display("FAIL holdoff_no_event: got ge=%0d, expected 1", gate_events);
        end
      end
    end
    adc_run = 1'b0;
    n_chk++;
    if (gate_events !== 16'd2 || active_cycles !== 16'd14) begin
      n_fail++;
      $display("FAIL holdoff_counters: got ge=%0d ac=%0d, expected ge=2 ac=14", gate_events, active_cycles);
    end
  endtask

  task automatic test_sleep_run();
    int         st_e[8] = '{1, 1, 1, 2, 2, 2, 2, 0};
    logic [7:0] en_e = 8'b0111_1111;
    logic [7:0] wp_e = 8'b0000_0001;
    exp_t       e;
    en_sleepmode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      clock_select = (i < 3) ? 2'b00 : 2'b01;
      sb.push_back('{en: en_e[i], st: 2'(st_e[i]), wp: wp_e[i]});
      tick();
      e = sb.pop_front();
      n_chk++;
      if (clk_en !== e.en || gate_state !== e.st || wake_pulse !== e.wp) begin
        n_fail++;
        $display("FAIL sleep_run step %0d: got en=%b st=%0d wp=%b, expected en=%b st=%0d wp=%b",
                 i, clk_en, gate_state, wake_pulse, e.en, e.st, e.wp);
      end
      if (i == 0) begin
        n_chk++;
        if (wake_src !== 7'b0000010) begin
          n_fail++;
          $display("FAIL wake_src_sleep_run: got %b, expected 0000010", wake_src);
        end
      end
    end
    en_sleepmode = 1'b1;
    n_chk++;
    if (gate_events !== 16'd3 || active_cycles !== 16'd21) begin
      n_fail++;
      $display("FAIL sleep_counters: got ge=%0d ac=%0d, expected ge=3 ac=21", gate_events, active_cycles);
    end
  endtask

  task automatic test_mask_force_reset();
    int         st_e[8] = '{0, 0, 0, 1, 1, 2, 2, 0};
    logic [7:0] en_e = 8'b0111_1000;
    logic [7:0] wp_e = 8'b0000_1000;
    exp_t       e;
    ungate_mask = 3'b000; ungate_req = 3'b111; en_sleepmode = 1'b1; clock_select = 2'b01;
    for (int i = 0; i < 8; i++) begin
      dis_hfclock_gating = (i == 3) || (i == 4);
      reset = (i == 7);
      sb.push_back('{en: en_e[i], st: 2'(st_e[i]), wp: wp_e[i]});
      tick();
      e = sb.pop_front();
      n_chk++;
      if (clk_en !== e.en || gate_state !== e.st || wake_pulse !== e.wp) begin
        n_fail++;
        $display("FAIL mask_force step %0d: got en=%b st=%0d wp=%b, expected en=%b st=%0d wp=%b",
                 i, clk_en, gate_state, wake_pulse, e.en, e.st, e.wp);
      end
      if (i == 3) begin
        n_chk++;
        if (wake_src !== 7'b0000001) begin
          n_fail++;
          $display("FAIL wake_src_masked: got %b, expected 0000001", wake_src);
        end
      end
    end
    n_chk++;
    if (gate_events !== 16'd0 || active_cycles !== 16'd0 || wake_src !== 7'd0) begin
      n_fail++;
      $display("FAIL midhold_reset: got ge=%0d ac=%0d ws=%b, expected 0 0 0",
               gate_events, active_cycles, wake_src);
    end
    reset = 1'b0; ungate_req = '0; ungate_mask = 3'b111; dis_hfclock_gating = 1'b0;
  endtask

  task automatic test_saturation();
    int         st_e[6] = '{1, 2, 2, 2, 2, 0};
    logic [5:0] en_e = 6'b01_1111;
    exp_t       e;
    for (int c = 0; c < 21; c++) begin
      for (int j = 0; j < 6; j++) begin
        dis_hfclock_gating = (j == 0);
        cnt_clr = (c == 20) && (j == 5);
        sb.push_back('{en: en_e[j], st: 2'(st_e[j]), wp: (j == 0)});
        tick();
        e = sb.pop_front();
        n_chk++;
        if (clk_en !== e.en || gate_state !== e.st || wake_pulse !== e.wp ||
            s_clk_en !== e.en || s_gate_state !== e.st) begin
          n_fail++;
          $display("FAIL sat cycle %0d step %0d: got en=%b/%b st=%0d/%0d wp=%b, expected en=%b st=%0d wp=%b",
                   c, j, clk_en, s_clk_en, gate_state, s_gate_state, wake_pulse, e.en, e.st, e.wp);
        end
      end
      if (c == 19) begin
        n_chk++;
        if (gate_events !== 16'd20 || active_cycles !== 16'd100) begin
          n_fail++;
          $display("FAIL wide_counters: got ge=%0d ac=%0d, expected ge=20 ac=100", gate_events, active_cycles);
        end
        n_chk++;
        if (s_gate_events !== 4'd15 || s_active_cycles !== 4'd15) begin
          n_fail++;
          $display("FAIL saturate: got ge=%0d ac=%0d, expected ge=15 ac=15", s_gate_events, s_active_cycles);
        end
      end
    end
    n_chk++;
    if (gate_events !== 16'd0 || active_cycles !== 16'd0 || s_gate_events !== 4'd0 || s_active_cycles !== 4'd0) begin
      n_fail++;
      $display("FAIL clr_on_gate_edge: got ge=%0d/%0d ac=%0d/%0d, expected all 0",
               gate_events, s_gate_events, active_cycles, s_active_cycles);
    end
    cnt_clr = 1'b0;
    tick();
    n_chk++;
    if (gate_events !== 16'd0 || active_cycles !== 16'd0 || gate_state !== 2'd0) begin
      n_fail++;
      $display("FAIL post_clr_idle: got ge=%0d ac=%0d st=%0d, expected 0 0 0",
               gate_events, active_cycles, gate_state);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wake();
    test_holdoff_reassert();
    test_sleep_run();
    test_mask_force_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
